// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle control unit for simple_cpu with memory handshake, watchdog and retire counter
module cpu_ctrl_fsm #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 8
) (
  input  logic             clk_50mhz,
  input  logic             key0_n,
  input  logic             run,
  input  logic [15:0]      ir,
  input  logic             zero_flag,
  input  logic             carry_flag,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             mem_we,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             acc_load,
  output logic [1:0]       acc_src,
  output logic             alu_op,
  output logic             alu_b_sel,
  output logic             illegal,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state_dbg,
  output logic [CNT_W-1:0] instr_retired
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;
  localparam int WW = $clog2(MAX_WAIT + 2);
  logic [2:0]       r_state, w_next, w_after;
  logic [WW-1:0]    r_wait;
  logic [CNT_W-1:0] r_retired;
  logic [3:0]       w_op;
  logic w_unused, w_mem_st, w_timeout, w_exec_op, w_mem_op, w_ill_op, w_retire, w_ex, w_mack;
  assign w_op      = ir[15:12];
  assign w_unused  = ^ir[11:0];
  assign w_mem_st  = r_state == S_FETCH || r_state == S_MEM;
  // counter holds the number of unacked cycles already spent, so the last allowed cycle sees MAX_WAIT-1
  assign w_timeout = MAX_WAIT != 0 && w_mem_st && !mem_ack && 32'(r_wait) + 32'd1 == 32'(MAX_WAIT);
  assign w_exec_op = w_op inside {4'h1, 4'h6, 4'h7, 4'h8, 4'h9};
  assign w_mem_op  = w_op inside {4'h2, 4'h3, 4'h4, 4'h5};
  assign w_ill_op  = w_op inside {[4'hA:4'hE]};
  assign w_after   = run ? S_FETCH : S_IDLE;
  assign w_ex      = r_state == S_EXEC;
  assign w_mack    = r_state == S_MEM && mem_ack;
  assign w_retire  = (r_state == S_DECODE && (w_op == 4'h0 || w_op == 4'hF)) || w_ex || w_mack;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = w_after;
      S_FETCH:  w_next = mem_ack ? S_DECODE : w_timeout ? S_FAULT : S_FETCH;
      S_DECODE: w_next = w_op == 4'hF ? S_HALT : w_exec_op ? S_EXEC : w_mem_op ? S_MEM : w_after;
      S_EXEC:   w_next = w_after;
      S_MEM:    w_next = mem_ack ? w_after : w_timeout ? S_FAULT : S_MEM;
      default:  w_next = r_state;
    endcase
  end
  always_ff @(posedge clk_50mhz or negedge key0_n) begin
    if (!key0_n) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_retired <= '0;
    end else begin
      r_state   <= w_next;
      r_wait    <= (w_mem_st && !mem_ack && !w_timeout) ? r_wait + WW'(1) : '0;
      r_retired <= r_retired + CNT_W'(w_retire);
    end
  end
  assign mem_req       = w_mem_st;
  assign mem_sel       = r_state == S_MEM;
  assign mem_we        = r_state == S_MEM && w_op == 4'h3;
  assign ir_load       = r_state == S_FETCH && mem_ack;
  assign pc_inc        = ir_load;
  assign pc_load       = w_ex && (w_op == 4'h7 || (w_op == 4'h8 && zero_flag) || (w_op == 4'h9 && carry_flag));
  assign acc_load      = (w_ex && (w_op == 4'h1 || w_op == 4'h6)) || (w_mack && (w_op == 4'h2 || w_op == 4'h4 || w_op == 4'h5));
  assign acc_src       = ((w_ex && w_op == 4'h6) || (w_mack && (w_op == 4'h4 || w_op == 4'h5))) ? 2'b10 :
                         (w_mack && w_op == 4'h2) ? 2'b01 : 2'b00;
  assign alu_op        = w_mack && w_op == 4'h5;
  assign alu_b_sel     = w_ex && w_op == 4'h6;
  assign illegal       = r_state == S_DECODE && w_ill_op;
  assign halted        = r_state == S_HALT;
  assign fault         = r_state == S_FAULT;
  assign state_dbg     = r_state;
  assign instr_retired = r_retired;
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: directed scenarios plus randomized instruction streams against a per-instruction cycle schedule
module tb_cpu_ctrl_fsm;
  logic clk_50mhz = 1'b0, key0_n = 1'b0, run = 1'b0, zero_flag = 1'b0, carry_flag = 1'b0, mem_ack = 1'b0;
  logic [15:0] ir = 16'h0;
  logic mem_req, mem_sel, mem_we, ir_load, pc_inc, pc_load, acc_load, alu_op, alu_b_sel, illegal, halted, fault;
  logic [1:0] acc_src;
  logic [2:0] state_dbg;
  logic [7:0] instr_retired;
  int total = 0, bad = 0;
  localparam logic [13:0] M_REQ = 14'h2000, M_SEL = 14'h1000, M_WE = 14'h0800, M_IRL = 14'h0400;
  localparam logic [13:0] M_PCI = 14'h0200, M_PCL = 14'h0100, M_ACC = 14'h0080, M_SRC_ALU = 14'h0040;
  localparam logic [13:0] M_SRC_MEM = 14'h0020, M_ALU = 14'h0010, M_BSEL = 14'h0008, M_ILL = 14'h0004;
  localparam logic [13:0] M_HLT = 14'h0002, M_FLT = 14'h0001, M_NONE = 14'h0000;
  typedef struct packed {logic [2:0] st; logic ack; logic rn; logic [13:0] e;} cyc_t;
  cpu_ctrl_fsm #(.MAX_WAIT(15), .CNT_W(8)) dut (
    .clk_50mhz(clk_50mhz), .key0_n(key0_n), .run(run), .ir(ir), .zero_flag(zero_flag),
    .carry_flag(carry_flag), .mem_ack(mem_ack), .mem_req(mem_req), .mem_sel(mem_sel), .mem_we(mem_we),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .acc_load(acc_load), .acc_src(acc_src),
    .alu_op(alu_op), .alu_b_sel(alu_b_sel), .illegal(illegal), .halted(halted), .fault(fault),
    .state_dbg(state_dbg), .instr_retired(instr_retired)
  );
  always #5 clk_50mhz = ~clk_50mhz;
  function automatic logic [16:0] obs();
    return {state_dbg, mem_req, mem_sel, mem_we, ir_load, pc_inc, pc_load, acc_load, acc_src,
            alu_op, alu_b_sel, illegal, halted, fault};
  endfunction
  function automatic logic [13:0] exec_mask(logic [3:0] op, logic zf, logic cf);
    return op == 4'h1 ? M_ACC : op == 4'h6 ? (M_ACC | M_SRC_ALU | M_BSEL) : op == 4'h7 ? M_PCL :
           op == 4'h8 ? (zf ? M_PCL : M_NONE) : op == 4'h9 ? (cf ? M_PCL : M_NONE) : M_NONE;
  endfunction
  function automatic logic [13:0] mem_ack_mask(logic [3:0] op);
    return op == 4'h2 ? (M_ACC | M_SRC_MEM) : op == 4'h4 ? (M_ACC | M_SRC_ALU) :
           op == 4'h5 ? (M_ACC | M_SRC_ALU | M_ALU) : M_NONE;
  endfunction
  task automatic step();
    @(posedge clk_50mhz);
    #1;
  endtask
  task automatic do_reset();
    key0_n = 1'b0; run = 1'b0; mem_ack = 1'b0; zero_flag = 1'b0; carry_flag = 1'b0;
    #2 key0_n = 1'b1;
    step();
  endtask
  task automatic test_reset();
    key0_n = 1'b0;
    #1;
    total++; if (obs() !== 17'd0) begin bad++; $display("FAIL reset_outputs got=%h want=%h", obs(), 17'd0); end
    total++; if (instr_retired !== 8'd0) begin bad++; $display("FAIL reset_retired got=%0d want=0", instr_retired); end
    #1 key0_n = 1'b1;
    step();
    run = 1'b1;
    step();
    #1;
    total++; if (obs() !== {3'd1, M_REQ}) begin bad++; $display("FAIL pre_reset_fetch got=%h want=%h", obs(), {3'd1, M_REQ}); end
    key0_n = 1'b0;
    #1;
    total++; if (obs() !== 17'd0) begin bad++; $display("FAIL async_reset got=%h want=%h", obs(), 17'd0); end
    key0_n = 1'b1; run = 1'b0;
    step();
  endtask
  task automatic test_ldi();
    do_reset();
    run = 1'b1; ir = 16'h1005; mem_ack = 1'b1;
    #1;
    total++; if (obs() !== {3'd0, M_NONE}) begin bad++; $display("FAIL ldi_idle got=%h want=%h", obs(), {3'd0, M_NONE}); end
    step(); #1;
    total++; if (obs() !== {3'd1, M_REQ | M_IRL | M_PCI}) begin bad++; $display("FAIL ldi_fetch got=%h want=%h", obs(), {3'd1, M_REQ | M_IRL | M_PCI}); end
    step(); #1;
    total++; if (obs() !== {3'd2, M_NONE}) begin bad++; $display("FAIL ldi_decode got=%h want=%h", obs(), {3'd2, M_NONE}); end
    step(); #1;
    total++; if (obs() !== {3'd3, M_ACC}) begin bad++; $display("FAIL ldi_exec got=%h want=%h", obs(), {3'd3, M_ACC}); end
    step(); #1;
    total++; if (instr_retired !== 8'd1) begin bad++; $display("FAIL ldi_retired got=%0d want=1", instr_retired); end
    total++; if (obs() !== {3'd1, M_REQ | M_IRL | M_PCI}) begin bad++; $display("FAIL ldi_refetch got=%h want=%h", obs(), {3'd1, M_REQ | M_IRL | M_PCI}); end
  endtask
  task automatic test_add_wait();
    logic [16:0] e;
    do_reset();
    run = 1'b1; ir = 16'h4020; mem_ack = 1'b1;
    step(); step();
    mem_ack = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      mem_ack = k == 3;
      if (k == 3) run = 1'b0;
      #1;
      e = {3'd4, M_REQ | M_SEL | (k == 3 ? (M_ACC | M_SRC_ALU) : M_NONE)};
      total++; if (obs() !== e) begin bad++; $display("FAIL add_mem_cycle%0d got=%h want=%h", k, obs(), e); end
      step();
    end
    #1;
    total++; if (obs() !== {3'd0, M_NONE}) begin bad++; $display("FAIL add_after got=%h want=%h", obs(), {3'd0, M_NONE}); end
    total++; if (instr_retired !== 8'd1) begin bad++; $display("FAIL add_retired got=%0d want=1", instr_retired); end
  endtask
  task automatic test_jz();
    do_reset();
    run = 1'b1; ir = 16'h8042; zero_flag = 1'b1; mem_ack = 1'b1;
    step(); step(); step(); #1;
    total++; if (obs() !== {3'd3, M_PCL}) begin bad++; $display("FAIL jz_taken got=%h want=%h", obs(), {3'd3, M_PCL}); end
    step();
    zero_flag = 1'b0;
    step(); step(); #1;
    total++; if (obs() !== {3'd3, M_NONE}) begin bad++; $display("FAIL jz_not_taken got=%h want=%h", obs(), {3'd3, M_NONE}); end
    run = 1'b0;
    step(); #1;
    total++; if (obs() !== {3'd0, M_NONE}) begin bad++; $display("FAIL jz_idle got=%h want=%h", obs(), {3'd0, M_NONE}); end
    total++; if (instr_retired !== 8'd2) begin bad++; $display("FAIL jz_retired got=%0d want=2", instr_retired); end
  endtask
  task automatic test_watchdog();
    do_reset();
    ir = 16'h0000; run = 1'b1;
    step();
    for (int i = 1; i <= 15; i++) begin
      #1;
      total++; if (obs() !== {3'd1, M_REQ}) begin bad++; $display("FAIL wd_wait%0d got=%h want=%h", i, obs(), {3'd1, M_REQ}); end
      step();
    end
    #1;
    total++; if (obs() !== {3'd6, M_FLT}) begin bad++; $display("FAIL wd_fault got=%h want=%h", obs(), {3'd6, M_FLT}); end
    run = 1'b0; mem_ack = 1'b1;
    step();
    run = 1'b1;
    step(); #1;
    total++; if (obs() !== {3'd6, M_FLT}) begin bad++; $display("FAIL wd_sticky got=%h want=%h", obs(), {3'd6, M_FLT}); end
    do_reset();
    run = 1'b1;
    step();
    for (int i = 1; i <= 15; i++) begin
      mem_ack = i == 15;
      step();
    end
    mem_ack = 1'b0;
    #1;
    total++; if (obs() !== {3'd2, M_NONE}) begin bad++; $display("FAIL wd_ack_wins got=%h want=%h", obs(), {3'd2, M_NONE}); end
  endtask
  task automatic test_halt();
    do_reset();
    ir = 16'hF000; run = 1'b1; mem_ack = 1'b1;
    step(); step(); #1;
    total++; if (obs() !== {3'd2, M_NONE}) begin bad++; $display("FAIL halt_decode got=%h want=%h", obs(), {3'd2, M_NONE}); end
    step(); #1;
    total++; if (obs() !== {3'd5, M_HLT}) begin bad++; $display("FAIL halt_state got=%h want=%h", obs(), {3'd5, M_HLT}); end
    total++; if (instr_retired !== 8'd1) begin bad++; $display("FAIL halt_retired got=%0d want=1", instr_retired); end
    for (int i = 0; i < 4; i++) begin
      run = ~run; mem_ack = 1'($urandom);
      step(); #1;
      total++; if (obs() !== {3'd5, M_HLT}) begin bad++; $display("FAIL halt_sticky%0d got=%h want=%h", i, obs(), {3'd5, M_HLT}); end
    end
    key0_n = 1'b0;
    #1;
    total++; if (obs() !== 17'd0) begin bad++; $display("FAIL halt_reset got=%h want=%h", obs(), 17'd0); end
    total++; if (instr_retired !== 8'd0) begin bad++; $display("FAIL halt_reset_retired got=%0d want=0", instr_retired); end
    key0_n = 1'b1; run = 1'b0;
    step();
  endtask
  task automatic test_illegal();
    do_reset();
    ir = 16'hB000; run = 1'b1; mem_ack = 1'b1;
    step(); step();
    mem_ack = 1'b0;
    #1;
    total++; if (obs() !== {3'd2, M_ILL}) begin bad++; $display("FAIL ill_pulse got=%h want=%h", obs(), {3'd2, M_ILL}); end
    step(); #1;
    total++; if (obs() !== {3'd1, M_REQ}) begin bad++; $display("FAIL ill_after got=%h want=%h", obs(), {3'd1, M_REQ}); end
    total++; if (instr_retired !== 8'd0) begin bad++; $display("FAIL ill_retired got=%0d want=0", instr_retired); end
    ir = 16'h2010; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step(); #1;
    total++; if (obs() !== {3'd4, M_REQ | M_SEL}) begin bad++; $display("FAIL lda_mem got=%h want=%h", obs(), {3'd4, M_REQ | M_SEL}); end
    key0_n = 1'b0;
    #1;
    total++; if (obs() !== 17'd0) begin bad++; $display("FAIL reset_mid_mem got=%h want=%h", obs(), 17'd0); end
    key0_n = 1'b1; run = 1'b0;
    step();
  endtask
  task automatic test_random();
    cyc_t q[$];
    logic [3:0] op;
    logic [15:0] w;
    logic zf, cf, idle;
    int df, dm;
    int unsigned ret;
    do_reset();
    idle = 1'b1; ret = 0;
    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom_range(0, 14)); w = {op, 12'($urandom)};
      zf = 1'($urandom); cf = 1'($urandom);
      df = $urandom_range(0, 4); dm = $urandom_range(0, 4);
      q.delete();
      if (idle) q.push_back('{3'd0, 1'($urandom), 1'b1, M_NONE});
      for (int k = 0; k <= df; k++)
        q.push_back('{3'd1, k == df, 1'($urandom), k == df ? (M_REQ | M_IRL | M_PCI) : M_REQ});
      q.push_back('{3'd2, 1'($urandom), 1'($urandom), op inside {[4'hA:4'hE]} ? M_ILL : M_NONE});
      if (op inside {4'h1, 4'h6, 4'h7, 4'h8, 4'h9})
        q.push_back('{3'd3, 1'($urandom), 1'($urandom), exec_mask(op, zf, cf)});
      else if (op inside {[4'h2:4'h5]})
        for (int k = 0; k <= dm; k++)
          q.push_back('{3'd4, k == dm, 1'($urandom),
                        M_REQ | M_SEL | (op == 4'h3 ? M_WE : M_NONE) | (k == dm ? mem_ack_mask(op) : M_NONE)});
      idle = !q[q.size()-1].rn;
      if (!(op inside {[4'hA:4'hE]})) ret++;
      foreach (q[i]) begin
        ir = w; zero_flag = zf; carry_flag = cf; mem_ack = q[i].ack; run = q[i].rn;
        #1;
        total++; if (obs() !== {q[i].st, q[i].e}) begin bad++; $display("FAIL rand_cycle instr=%0d ir=%h got=%h want=%h", n, w, obs(), {q[i].st, q[i].e}); end
        step();
      end
      total++; if (instr_retired !== 8'(ret)) begin bad++; $display("FAIL rand_retired instr=%0d got=%0d want=%0d", n, instr_retired, 8'(ret)); end
    end
  endtask
  initial begin
    test_reset();
    test_ldi();
    test_add_wait();
    test_jz();
    test_watchdog();
    test_halt();
    test_illegal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
